// File: rtl/fma_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FMA pipeline between two requesters,
// with rm resolution, result routing, sticky fflags and flush/drain. Optional macro: FMA_ISSUE_STATS_EN.
module fma_issue_arbiter #(
  parameter int unsigned          PARM_XLEN   = 32,
  parameter int unsigned          PARM_RM     = 3,
  parameter int unsigned          PARM_LAT    = 3,
  parameter logic [PARM_RM-1:0]   PARM_RM_DYN = 3'b111
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [PARM_XLEN-1:0] req0_a_i,
  input  logic [PARM_XLEN-1:0] req0_b_i,
  input  logic [PARM_XLEN-1:0] req0_c_i,
  input  logic [PARM_RM-1:0]   req0_rm_i,
  input  logic                 req0_sub_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [PARM_XLEN-1:0] req1_a_i,
  input  logic [PARM_XLEN-1:0] req1_b_i,
  input  logic [PARM_XLEN-1:0] req1_c_i,
  input  logic [PARM_RM-1:0]   req1_rm_i,
  input  logic                 req1_sub_i,
  output logic                 fma_valid_o,
  output logic [PARM_XLEN-1:0] fma_a_o,
  output logic [PARM_XLEN-1:0] fma_b_o,
  output logic [PARM_XLEN-1:0] fma_c_o,
  output logic [PARM_RM-1:0]   fma_rm_o,
  output logic                 fma_sub_o,
  input  logic [PARM_XLEN-1:0] fma_result_i,
  input  logic [3:0]           fma_flags_i,
  output logic                 rsp0_valid_o,
  output logic                 rsp1_valid_o,
  output logic [PARM_XLEN-1:0] rsp_data_o,
  input  logic                 frm_we_i,
  input  logic [PARM_RM-1:0]   frm_i,
  input  logic                 fflags_clr_i,
  output logic [4:0]           fflags_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 illegal_rm_o
`ifdef FMA_ISSUE_STATS_EN
  ,
  output logic [31:0]          issue_cnt0_o,
  output logic [31:0]          issue_cnt1_o,
  output logic [15:0]          flush_cnt_o
`endif
);

  localparam logic [PARM_XLEN-1:0] CANON_NAN = PARM_XLEN'(32'h7FC0_0000);
  localparam int unsigned          CW         = (PARM_LAT > 1) ? $clog2(PARM_LAT) : 1;
  localparam logic [CW-1:0]        DRAIN_LAST = CW'(PARM_LAT - 1);

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic synth;
  } tag_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          drain_cnt_q, drain_cnt_d;
  logic                   ptr_q;
  logic [PARM_RM-1:0]     frm_q;
  logic [4:0]             fflags_q;
  logic [PARM_XLEN-1:0]   rsp_data_q;
  tag_t                   tag_q [PARM_LAT];

  logic                   grant, grant_id, illegal;
  logic [PARM_RM-1:0]     sel_rm, res_rm;
  logic [PARM_XLEN-1:0]   sel_a, sel_b, sel_c, out_data;
  logic                   sel_sub, any_valid, out_live;
  logic [4:0]             flag_set;
  tag_t                   out_tag;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (!rst_i && state_q == RUN && !flush_i) begin
      if (req0_valid_i && req1_valid_i) begin
        grant    = 1'b1;
        grant_id = ptr_q;
      end else if (req0_valid_i) begin
        grant = 1'b1;
      end else if (req1_valid_i) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign sel_a   = grant_id ? req1_a_i   : req0_a_i;
  assign sel_b   = grant_id ? req1_b_i   : req0_b_i;
  assign sel_c   = grant_id ? req1_c_i   : req0_c_i;
  assign sel_sub = grant_id ? req1_sub_i : req0_sub_i;
  assign sel_rm  = grant_id ? req1_rm_i  : req0_rm_i;

  // A dynamic rm sees the frm value registered before this cycle's write.
  assign res_rm  = (sel_rm == PARM_RM_DYN) ? frm_q : sel_rm;
  assign illegal = (res_rm == PARM_RM'(3'b101)) || (res_rm == PARM_RM'(3'b110)) ||
                   (res_rm == PARM_RM'(3'b111));

  assign req0_ready_o = grant && !grant_id;
  assign req1_ready_o = grant &&  grant_id;
  assign fma_valid_o  = grant && !illegal;
  assign illegal_rm_o = grant &&  illegal;
  assign fma_a_o      = fma_valid_o ? sel_a   : '0;
  assign fma_b_o      = fma_valid_o ? sel_b   : '0;
  assign fma_c_o      = fma_valid_o ? sel_c   : '0;
  assign fma_sub_o    = fma_valid_o ? sel_sub : 1'b0;
  assign fma_rm_o     = fma_valid_o ? res_rm  : '0;

  // A flush squashes the entry sitting in the output stage as well.
  assign out_tag      = tag_q[PARM_LAT-1];
  assign out_live     = out_tag.valid && !flush_i;
  assign out_data     = out_tag.synth ? CANON_NAN : fma_result_i;
  assign rsp0_valid_o = out_live && !out_tag.id;
  assign rsp1_valid_o = out_live &&  out_tag.id;
  assign rsp_data_o   = out_live ? out_data : rsp_data_q;
  assign fflags_o     = fflags_q;

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(PARM_LAT); i++) any_valid = any_valid | tag_q[i].valid;
  end

  assign busy_o = any_valid || (state_q == DRAIN);

  always_comb begin
    flag_set = '0;
    if (out_live && !out_tag.synth)
      flag_set = {fma_flags_i[3], 1'b0, fma_flags_i[2], fma_flags_i[1], fma_flags_i[0]};
    if (illegal_rm_o) flag_set[4] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LAST;
        end
      end
      DRAIN: begin
        if (flush_i)                  drain_cnt_d = DRAIN_LAST;
        else if (drain_cnt_q == '0)   state_d     = RUN;
        else                          drain_cnt_d = drain_cnt_q - CW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      ptr_q       <= 1'b0;
      frm_q       <= '0;
      fflags_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (grant)    ptr_q      <= ~grant_id;
      if (frm_we_i) frm_q      <= frm_i;
      if (out_live) rsp_data_q <= out_data;
      // Clear wins: a same-cycle set is deliberately lost.
      fflags_q <= fflags_clr_i ? 5'b0 : (fflags_q | flag_set);
    end
  end

  // NOTE: the tag pipe is reset because its valid bits are control state; stale tags would emit phantom responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(PARM_LAT); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= flush_i ? tag_t'('0) : tag_t'{valid: grant, id: grant_id, synth: illegal};
      for (int i = 1; i < int'(PARM_LAT); i++) tag_q[i] <= flush_i ? tag_t'('0) : tag_q[i-1];
    end
  end

`ifdef FMA_ISSUE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt0_o <= '0;
      issue_cnt1_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (fma_valid_o && !grant_id) issue_cnt0_o <= issue_cnt0_o + 32'd1;
      if (fma_valid_o &&  grant_id) issue_cnt1_o <= issue_cnt1_o + 32'd1;
      if (flush_i)                  flush_cnt_o  <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fma_issue_arbiter.md
Name: fma_issue_arbiter

Overview:
- Shares one fixed-latency single-precision FMA pipeline between two requesters. The pipeline is the mantissa-multiply / add / normalise-and-round datapath.
- Grants issue slots round-robin and resolves the dynamic rounding mode against the frm register.
- Tracks in-flight ops with a tag shift register and routes each result back to its requester.
- Accumulates IEEE exception flags into a sticky fflags register and supports flush with drain.

Parameters:
- PARM_XLEN, 32, operand/result width.
- PARM_RM, 3, rounding-mode width.
- PARM_LAT, 3, FMA pipeline latency in cycles from issue to result, ≥1.
- PARM_RM_DYN, 3'b111, rm encoding meaning "use frm".

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req0_valid_i  in  1  requester 0 has an op
- req0_ready_o  out  1  requester 0 op accepted this cycle
- req0_a_i, req0_b_i, req0_c_i  in  PARM_XLEN each  operands (A addend, B*C product)
- req0_rm_i  in  PARM_RM  rounding mode
- req0_sub_i  in  1  subtract addend
- req1_*  same set as req0_*, for requester 1
- fma_valid_o  out  1  issue into FMA pipeline
- fma_a_o, fma_b_o, fma_c_o  out  PARM_XLEN each  issued operands
- fma_rm_o  out  PARM_RM  resolved rounding mode
- fma_sub_o  out  1  issued subtract
- fma_result_i  in  PARM_XLEN  pipeline result, valid PARM_LAT cycles after issue
- fma_flags_i  in  4  {invalid, overflow, underflow, inexact} from pipeline
- rsp0_valid_o, rsp1_valid_o  out  1  result return pulse
- rsp_data_o  out  PARM_XLEN  shared result bus
- frm_we_i  in  1  write frm
- frm_i  in  PARM_RM  new frm value
- fflags_clr_i  in  1  clear sticky flags
- fflags_o  out  5  sticky {NV,DZ,OF,UF,NX}
- flush_i  in  1  squash in-flight ops
- busy_o  out  1  ops in flight or draining
- illegal_rm_o  out  1  pulse: granted op had an illegal resolved rm

Behaviour:
- Reset values:
  - all outputs 0; frm=3'b000; fflags=0; round-robin pointer=0 (req0 favoured); tag pipe empty; state=RUN.
- States:
  - RUN: normal issue.
  - DRAIN: entered when flush_i=1. No grants. Valid bits of all tag-pipe entries are cleared the same cycle, so in-flight results are dropped and produce no rsp and no flag update. The pipe continues shifting; return to RUN after PARM_LAT cycles (counter).
  - flush_i asserted in DRAIN restarts the counter.
- Arbitration (RUN only):
  - One grant per cycle; req<n>_ready_o=1 only for the granted requester.
  - Both valid: grant the one at the pointer, then point to the other.
  - Single valid: grant it, and the pointer moves to the other requester.
  - No backpressure from the FMA: a grant always issues the same cycle (fma_valid_o = grant, operands muxed combinationally).
- Rounding mode:
  - rm==PARM_RM_DYN resolves to frm.
  - Resolved rm of 3'b101, 3'b110 or 3'b111 is illegal: grant is still given (op consumed), fma_valid_o=0, illegal_rm_o=1, NV set in fflags, and the requester gets rsp with data 32'h7FC00000 at the same latency as a real op.
  - frm_we_i takes effect the next cycle; a same-cycle DYN grant uses the old frm.
- Tag pipe:
  - PARM_LAT-deep shift register of {valid, id, synth}.
  - At the output stage with valid=1: pulse rsp<id>_valid_o, drive rsp_data_o = fma_result_i (or the canonical NaN when synth=1).
  - Flags update on non-synth entries only: OR fma_flags_i into fflags as NV, OF, UF, NX. DZ is never set by this block.
- fflags:
  - fflags_clr_i has priority over a same-cycle set.
  - A set and clear in the same cycle yields 0; the set is lost by design.
- busy_o = any tag valid OR state==DRAIN.
- rsp_data_o holds its last value when no rsp is pulsed.
- Async reset mid-operation discards all in-flight tags immediately; no rsp is produced afterwards.

Optional Feature:
- Macro FMA_ISSUE_STATS_EN.
- When defined:
  - adds outputs issue_cnt0_o and issue_cnt1_o (32 bits each), counting real issues per requester; synthetic illegal-rm ops excluded;
  - adds flush_cnt_o (16 bits), counting flush events;
  - all counters wrap at 2^N, reset to 0 on rst_i, and are unaffected by flush.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Both requesters valid continuously with PARM_LAT=3, rm=000:
  - grants alternate 0,1,0,1 starting with 0;
  - rsp pulses alternate 3 cycles after each grant, with correct data per id.
- req0 rm=111 with frm written to 3'b001 the previous cycle:
  - fma_rm_o=001.
  - With the frm write in the same cycle as the grant instead, fma_rm_o=000.
- req1 rm=101:
  - illegal_rm_o=1 and fma_valid_o=0 in the grant cycle;
  - 3 cycles later rsp1_valid_o=1 with rsp_data_o=32'h7FC00000;
  - fflags_o=5'b10000.
- Issue 3 back-to-back ops, then flush_i in the cycle after the last:
  - no rsp pulses;
  - busy_o high for 3 cycles then low;
  - a request asserted during DRAIN is granted only after return to RUN.
- FMA returns flags 4'b0101 then 4'b0001:
  - fflags_o=5'b00101 sticky.
  - fflags_clr_i concurrent with a flag return leaves fflags_o=0.
- Assert rst_i asynchronously with 2 ops in flight:
  - outputs are 0 immediately;
  - no rsp after release;
  - frm reads back 000.
